// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The CHK state is always declared; it is only reachable with IMEM_LOADER_CHECKSUM_EN.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CHK,
        FLUSH,
        DONE,
        ERROR
    } loader_state_t;

    localparam int LEN_W          = 16;
    localparam int BYTES_PER_WORD = 4;

    // States in which a stream byte may be accepted
    function automatic logic rx_open(input loader_state_t s);
        return (s == LEN0) || (s == LEN1) || (s == DATA) || (s == CHK);
    endfunction

    function automatic logic is_busy(input loader_state_t s);
        return (s == LEN0) || (s == LEN1) || (s == DATA) || (s == CHK) || (s == FLUSH);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer: the first byte of a word lands in bits [7:0].
// o_word_valid pulses for one cycle after the last byte of each word.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic [1:0]  o_idx,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    localparam logic [1:0] IDX_LAST = 2'(BYTES_PER_WORD - 1);

    logic [23:0] r_shift;
    logic [1:0]  r_idx;
    logic [31:0] r_word;
    logic        r_word_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift      <= '0;
            r_idx        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_clear) begin
                r_idx <= '0;
            end else if (i_valid) begin
                r_shift <= {i_data, r_shift[23:8]};
                r_idx   <= r_idx + 2'd1;
                if (r_idx == IDX_LAST) begin
                    r_word       <= {i_data, r_shift};
                    r_word_valid <= 1'b1;
                end
            end
        end
    end

    assign o_idx        = r_idx;
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte image, writes it into imem and holds
// the CPU in reset until complete. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR byte.
module imem_loader
    import loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 64,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [LEN_W-1:0]  DEPTH_L  = LEN_W'(IMEM_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [1:0]        IDX_LAST = 2'(BYTES_PER_WORD - 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t     TAIL_STATE = CHK;
`else
    localparam loader_state_t     TAIL_STATE = FLUSH;
`endif

    loader_state_t     r_state;
    loader_state_t     w_state_next;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_word_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rx_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic              r_cpu_reset;

    logic              w_accept;
    logic              w_data_accept;
    logic              w_start_ok;
    logic [LEN_W-1:0]  w_len_full;
    logic              w_last_word;
    logic              w_word_end;
    logic [1:0]        w_pack_idx;
    logic              w_word_valid;
    logic [31:0]       w_word;

    assign w_accept      = rx_valid && r_rx_ready;
    assign w_data_accept = w_accept && (r_state == DATA);
    assign w_start_ok    = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));
    assign w_len_full    = {rx_data, r_len[7:0]};
    assign w_last_word   = (r_word_cnt == (r_len - LEN_W'(1)));
    assign w_word_end    = w_data_accept && (w_pack_idx == IDX_LAST);

    byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_start_ok),
        .i_valid      (w_data_accept),
        .i_data       (rx_data),
        .o_idx        (w_pack_idx),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_csum <= '0;
        end else if (w_start_ok) begin
            r_csum <= '0;
        end else if (w_data_accept) begin
            r_csum <= r_csum ^ rx_data;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE, ERROR: begin
                if (start) w_state_next = LEN0;
            end
            LEN0: begin
                if (w_accept) w_state_next = LEN1;
            end
            LEN1: begin
                if (w_accept) begin
                    if (w_len_full > DEPTH_L)      w_state_next = ERROR;
                    else if (w_len_full == '0)     w_state_next = TAIL_STATE;
                    else                           w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_word_end && w_last_word) w_state_next = TAIL_STATE;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
                if (w_accept) w_state_next = (rx_data == r_csum) ? DONE : ERROR;
            end
`endif
            FLUSH:   w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    // Status outputs are registered decodes of the next state so they align with r_state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rx_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cpu_reset <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_rx_ready  <= rx_open(w_state_next);
            r_busy      <= is_busy(w_state_next);
            r_done      <= (w_state_next == DONE);
            r_error     <= (w_state_next == ERROR);
            r_cpu_reset <= (w_state_next != DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len      <= '0;
            r_word_cnt <= '0;
            r_addr     <= '0;
        end else if (w_start_ok) begin
            r_len      <= '0;
            r_word_cnt <= '0;
            r_addr     <= '0;
        end else begin
            if (w_accept && (r_state == LEN0)) r_len[7:0] <= rx_data;
            if (w_accept && (r_state == LEN1)) r_len      <= w_len_full;
            if (w_word_end)                     r_word_cnt <= r_word_cnt + LEN_W'(1);
            // Address parks on the last word so it only returns to 0 on a fresh start
            if (w_word_valid && (r_addr != ADDR_MAX)) r_addr <= r_addr + ADDR_W'(1);
        end
    end

    assign rx_ready  = r_rx_ready;
    assign imem_we   = w_word_valid;
    assign imem_addr = r_addr;
    assign imem_wd   = w_word;
    assign cpu_reset = r_cpu_reset;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver queues expected imem writes, a
// negedge monitor pops and compares address, data and arrival cycle.
module tb_imem_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wd;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;

    imem_loader #(.IMEM_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wd   (imem_wd),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        int            at;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  tb_csum = 8'h00;
    logic [31:0] img[0:DEPTH-1];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endfunction

    // Monitor: every imem write must match the head of the expected queue
    always @(negedge clk) begin
        wr_t e;
        if (!reset && imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h, required no write", imem_addr, imem_wd);
            end else begin
                e = exp_q.pop_front();
                $display("write addr=%0d data=0x%08h cycle=%0d", imem_addr, imem_wd, cyc);
                check("write_addr", 32'(imem_addr), 32'(e.addr));
                check("write_data", imem_wd, e.data);
                check("write_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps, output int acc);
        int waited;
        if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        acc      = -1;
        while (acc < 0) begin
            @(negedge clk);
            if (rx_ready) begin
                acc = cyc;
            end else begin
                waited++;
                if (waited > 64) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_ready_timeout: got rx_ready 0 for %0d cycles, required 1", waited);
                    acc = cyc;
                end
            end
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_word(input int addr, input logic [31:0] w, input bit gaps);
        int acc;
        acc = 0;
        for (int j = 0; j < 4; j++) begin
            send_byte(w[8*j +: 8], gaps, acc);
            tb_csum ^= w[8*j +: 8];
        end
        exp_q.push_back('{addr: AW'(addr), data: w, at: acc + 1});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic load_image(input int n, input bit gaps, input bit mid_starts);
        int acc;
        pulse_start();
        tb_csum = 8'h00;
        send_byte(n[7:0], gaps, acc);
        send_byte(n[15:8], gaps, acc);
        for (int i = 0; i < n; i++) begin
            send_word(i, img[i], gaps);
            if (mid_starts && (i % 16 == 7)) pulse_start();
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(tb_csum, gaps, acc);
`endif
    endtask

    // Called right after the final stream byte has been accepted
    task automatic finish_check();
`ifndef IMEM_LOADER_CHECKSUM_EN
        @(negedge clk);
        check("flush_done_low", 32'(done), 32'd0);
        check("flush_cpu_reset_high", 32'(cpu_reset), 32'd1);
`endif
        @(negedge clk);
        check("done", 32'(done), 32'd1);
        check("cpu_reset_released", 32'(cpu_reset), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc;
        acc = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset values, then idle with rx_valid asserted but never accepted
        @(negedge clk);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wd", imem_wd, 32'd0);
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (20) begin
            @(negedge clk);
            check("idle_rx_ready", 32'(rx_ready), 32'd0);
        end
        check("idle_cpu_reset", 32'(cpu_reset), 32'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;

        // Two-word image: 02 00 13 05 90 01 23 22 a0 06
        img[0] = 32'h01900513;
        img[1] = 32'h06a02223;
        load_image(2, 1'b0, 1'b0);
        finish_check();

        // Start from DONE, oversize length 0x41
        pulse_start();
        @(negedge clk);
        check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_rx_ready", 32'(rx_ready), 32'd1);
        @(posedge clk); #1;
        send_byte(8'h41, 1'b0, acc);
        send_byte(8'h00, 1'b0, acc);
        @(negedge clk);
        check("oversize_error", 32'(error), 32'd1);
        check("oversize_cpu_reset", 32'(cpu_reset), 32'd1);
        check("oversize_busy", 32'(busy), 32'd0);
        check("oversize_rx_ready", 32'(rx_ready), 32'd0);
        @(posedge clk); #1;

        // Zero-length image
        load_image(0, 1'b0, 1'b0);
        finish_check();
        check("zero_len_addr", 32'(imem_addr), 32'd0);

        // Full 64-word image with random gaps and ignored mid-load starts
        for (int i = 0; i < DEPTH; i++) img[i] = (32'(i) * 32'h01030507) ^ 32'hA5C30F1E;
        load_image(DEPTH, 1'b1, 1'b1);
        finish_check();

        // Reset after 5 data bytes, then a 1-word image
        img[0] = 32'hDEADBEEF;
        img[1] = 32'h0BADF00D;
        pulse_start();
        send_byte(8'h02, 1'b0, acc);
        send_byte(8'h00, 1'b0, acc);
        send_word(0, img[0], 1'b0);
        send_byte(img[1][7:0], 1'b0, acc);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("midrst_rx_ready", 32'(rx_ready), 32'd0);
        check("midrst_addr", 32'(imem_addr), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        img[0] = 32'hCAFEF00D;
        load_image(1, 1'b0, 1'b0);
        finish_check();

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 0x11223344: 44^33^22^11 = 0x44
        pulse_start();
        send_byte(8'h01, 1'b0, acc);
        send_byte(8'h00, 1'b0, acc);
        send_word(0, 32'h11223344, 1'b0);
        send_byte(8'h44, 1'b0, acc);
        @(negedge clk);
        check("csum_ok_done", 32'(done), 32'd1);
        check("csum_ok_error", 32'(error), 32'd0);
        check("csum_ok_cpu_reset", 32'(cpu_reset), 32'd0);
        @(posedge clk); #1;
        pulse_start();
        send_byte(8'h01, 1'b0, acc);
        send_byte(8'h00, 1'b0, acc);
        send_word(0, 32'h11223344, 1'b0);
        send_byte(8'h45, 1'b0, acc);
        @(negedge clk);
        check("csum_bad_error", 32'(error), 32'd1);
        check("csum_bad_done", 32'(done), 32'd0);
        check("csum_bad_cpu_reset", 32'(cpu_reset), 32'd1);
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by %0t, required completion", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
